// File: rtl/hsi_pkg.sv
// rtl/hsi_pkg.sv - shared source indices and scheduler state encoding
package hsi_pkg;

  // Frame source indices as they appear on req/ack/repeat_req
  localparam logic [1:0] SRC_SR  = 2'd0;
  localparam logic [1:0] SRC_TM  = 2'd1;
  localparam logic [1:0] SRC_BTC = 2'd2;
  localparam logic [1:0] SRC_CCW = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_TX       = 3'd2,
    ST_WAIT_RPL = 3'd3,
    ST_RX       = 3'd4,
    ST_GAP      = 3'd5
  } hsi_state_e;

  // One-hot pulse vector addressing a single source
  function automatic logic [3:0] src_onehot(input logic [1:0] idx);
    src_onehot = 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/hsi_prio_enc.sv
// rtl/hsi_prio_enc.sv - fixed-priority source selector (btc > ccw > sr > tm)
module hsi_prio_enc
  import hsi_pkg::*;
(
  input  logic [3:0] req,
  output logic [1:0] idx,
  output logic       valid
);

  // Pick the most urgent requesting source; valid low when nobody asks
  always_comb begin
    idx   = SRC_SR;
    valid = 1'b1;
    if (req[SRC_BTC]) begin
      idx = SRC_BTC;
    end else if (req[SRC_CCW]) begin
      idx = SRC_CCW;
    end else if (req[SRC_SR]) begin
      idx = SRC_SR;
    end else if (req[SRC_TM]) begin
      idx = SRC_TM;
    end else begin
      valid = 1'b0;
    end
  end

endmodule

// File: rtl/hsi_m_tx_sched.sv
// rtl/hsi_m_tx_sched.sv - frame transmit scheduler with reply timeout and retry
module hsi_m_tx_sched
  import hsi_pkg::*;
#(
  parameter logic [15:0] REPLY_TO   = 16'd2000,
  parameter logic [7:0]  GAP        = 8'd16,
  parameter int          MAX_RETRY  = 2,
  parameter logic [3:0]  REPLY_MASK = 4'b1011
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       en,
  input  logic [3:0] req,
  output logic       tx_start,
  output logic [1:0] tx_sel,
  input  logic       tx_done,
  input  logic       rx_start_bit,
  input  logic       rx_frame_end,
  input  logic       rx_err,
  output logic [3:0] ack,
  output logic [3:0] repeat_req,
  output logic       fail,
  output logic       switch_com_src_req,
  output logic       busy
);

  localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRY);

  hsi_state_e  state;
  logic [15:0] rpl_timer;
  logic [7:0]  gap_cnt;
  logic [3:0]  retry_cnt;
  logic        retry_pend;
  logic [1:0]  prio_idx;
  logic        prio_valid;
  logic        timeout;
  logic        attempt_failed;

  hsi_prio_enc u_prio (
    .req   (req),
    .idx   (prio_idx),
    .valid (prio_valid)
  );

  // The reply window covers REPLY_TO cycles; a start bit in the last one still counts
  assign timeout = (rpl_timer == (REPLY_TO - 16'd1));

  // Either a missing reply or a corrupted one ends the current attempt
  assign attempt_failed = ((state == ST_WAIT_RPL) && !rx_start_bit && timeout) ||
                          ((state == ST_RX) && rx_frame_end && rx_err);

  assign busy = (state != ST_IDLE);

  // Scheduler FSM with registered pulse outputs
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state              <= ST_IDLE;
      tx_start           <= 1'b0;
      tx_sel             <= 2'd0;
      ack                <= 4'd0;
      repeat_req         <= 4'd0;
      fail               <= 1'b0;
      switch_com_src_req <= 1'b0;
      rpl_timer          <= 16'd0;
      gap_cnt            <= 8'd0;
      retry_cnt          <= 4'd0;
      retry_pend         <= 1'b0;
    end else begin
      tx_start           <= 1'b0;
      ack                <= 4'd0;
      repeat_req         <= 4'd0;
      fail               <= 1'b0;
      switch_com_src_req <= 1'b0;

      case (state)
        ST_IDLE: begin
          // A retry belongs to the running transaction, so en does not hold it back
          if (retry_pend) begin
            retry_pend <= 1'b0;
            tx_start   <= 1'b1;
            state      <= ST_START;
          end else if (en && prio_valid) begin
            tx_sel   <= prio_idx;
            tx_start <= 1'b1;
            state    <= ST_START;
          end
        end
        ST_START: begin
          state <= ST_TX;
        end
        ST_TX: begin
          if (tx_done) begin
            if (REPLY_MASK[tx_sel]) begin
              rpl_timer <= 16'd0;
              state     <= ST_WAIT_RPL;
            end else begin
              ack       <= src_onehot(tx_sel);
              retry_cnt <= 4'd0;
              gap_cnt   <= 8'd0;
              state     <= ST_GAP;
            end
          end
        end
        ST_WAIT_RPL: begin
          if (rx_start_bit) begin
            state <= ST_RX;
          end else if (!timeout) begin
            rpl_timer <= rpl_timer + 16'd1;
          end
        end
        ST_RX: begin
          if (rx_frame_end && !rx_err) begin
            ack       <= src_onehot(tx_sel);
            retry_cnt <= 4'd0;
            gap_cnt   <= 8'd0;
            state     <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_cnt == (GAP - 8'd1)) begin
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase

      if (attempt_failed) begin
        gap_cnt <= 8'd0;
        state   <= ST_GAP;
        if (retry_cnt < RETRY_LIMIT) begin
          retry_cnt  <= retry_cnt + 4'd1;
          repeat_req <= src_onehot(tx_sel);
          retry_pend <= 1'b1;
        end else begin
          fail               <= 1'b1;
          switch_com_src_req <= 1'b1;
          retry_cnt          <= 4'd0;
          retry_pend         <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_hsi_m_tx_sched.sv
// tb/tb_hsi_m_tx_sched.sv - directed bench with a transaction-level reference model
module tb_hsi_m_tx_sched;

  localparam logic [15:0] REPLY_TO   = 16'd2000;
  localparam logic [7:0]  GAP        = 8'd16;
  localparam int          MAX_RETRY  = 2;
  localparam logic [3:0]  REPLY_MASK = 4'b1011;

  localparam int P_IDLE = 0, P_START = 1, P_TX = 2, P_WAIT = 3, P_RX = 4, P_GAP = 5;
  localparam int W_START = 0, W_ACK = 1, W_REP = 2, W_FAIL = 3;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       en = 1'b0;
  logic [3:0] req = 4'd0;
  logic       tx_done = 1'b0;
  logic       rx_start_bit = 1'b0;
  logic       rx_frame_end = 1'b0;
  logic       rx_err = 1'b0;
  logic       tx_start;
  logic [1:0] tx_sel;
  logic [3:0] ack;
  logic [3:0] repeat_req;
  logic       fail;
  logic       switch_com_src_req;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // model state: phase, granted source, attempts used, cycles left in window/gap
  int   m_phase = P_IDLE;
  int   m_sel = 0;
  int   m_tries = 0;
  int   m_left = 0;
  bit   m_pend = 1'b0;
  logic e_start = 1'b0;
  logic [3:0] e_ack = 4'd0;
  logic [3:0] e_rep = 4'd0;
  logic e_fail = 1'b0;

  hsi_m_tx_sched #(
    .REPLY_TO   (REPLY_TO),
    .GAP        (GAP),
    .MAX_RETRY  (MAX_RETRY),
    .REPLY_MASK (REPLY_MASK)
  ) dut (
    .clk                (clk),
    .n_rst              (n_rst),
    .en                 (en),
    .req                (req),
    .tx_start           (tx_start),
    .tx_sel             (tx_sel),
    .tx_done            (tx_done),
    .rx_start_bit       (rx_start_bit),
    .rx_frame_end       (rx_frame_end),
    .rx_err             (rx_err),
    .ack                (ack),
    .repeat_req         (repeat_req),
    .fail               (fail),
    .switch_com_src_req (switch_com_src_req),
    .busy               (busy)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // priority order written as a plain list, most urgent first
  function automatic int pick(input logic [3:0] r);
    int order [4];
    order = '{2, 3, 0, 1};
    pick = -1;
    for (int i = 0; i < 4; i++) begin
      if (pick < 0 && r[order[i]]) pick = order[i];
    end
  endfunction

  task automatic attempt_lost();
    if (m_tries < MAX_RETRY) begin
      m_tries++;
      e_rep  = 4'(1 << m_sel);
      m_pend = 1'b1;
    end else begin
      e_fail  = 1'b1;
      m_tries = 0;
    end
    m_phase = P_GAP;
    m_left  = int'(GAP);
  endtask

  task automatic model_step();
    e_start = 1'b0;
    e_ack   = 4'd0;
    e_rep   = 4'd0;
    e_fail  = 1'b0;
    if (!n_rst) begin
      m_phase = P_IDLE;
      m_sel   = 0;
      m_tries = 0;
      m_left  = 0;
      m_pend  = 1'b0;
      return;
    end
    case (m_phase)
      P_IDLE: begin
        if (m_pend) begin
          m_pend  = 1'b0;
          e_start = 1'b1;
          m_phase = P_START;
        end else if (en && req != 4'd0) begin
          m_sel   = pick(req);
          e_start = 1'b1;
          m_phase = P_START;
        end
      end
      P_START: m_phase = P_TX;
      P_TX: begin
        if (tx_done) begin
          if (REPLY_MASK[m_sel]) begin
            m_phase = P_WAIT;
            m_left  = int'(REPLY_TO);
          end else begin
            e_ack   = 4'(1 << m_sel);
            m_tries = 0;
            m_phase = P_GAP;
            m_left  = int'(GAP);
          end
        end
      end
      P_WAIT: begin
        if (rx_start_bit) begin
          m_phase = P_RX;
        end else begin
          m_left--;
          if (m_left == 0) attempt_lost();
        end
      end
      P_RX: begin
        if (rx_frame_end) begin
          if (!rx_err) begin
            e_ack   = 4'(1 << m_sel);
            m_tries = 0;
            m_phase = P_GAP;
            m_left  = int'(GAP);
          end else begin
            attempt_lost();
          end
        end
      end
      P_GAP: begin
        m_left--;
        if (m_left == 0) m_phase = P_IDLE;
      end
      default: m_phase = P_IDLE;
    endcase
  endtask

  initial forever begin
    @(posedge clk or negedge n_rst);
    model_step();
  end

  // every cycle: DUT outputs against the model
  initial forever begin
    @(negedge clk);
    chk("tx_start", 32'(tx_start), 32'(e_start));
    chk("tx_sel", 32'(tx_sel), 32'(m_sel));
    chk("ack", 32'(ack), 32'(e_ack));
    chk("repeat_req", 32'(repeat_req), 32'(e_rep));
    chk("fail", 32'(fail), 32'(e_fail));
    chk("switch_com_src_req", 32'(switch_com_src_req), 32'(e_fail));
    chk("busy", 32'(busy), 32'(m_phase != P_IDLE));
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse(input int which);
    case (which)
      0: tx_done = 1'b1;
      1: rx_start_bit = 1'b1;
      default: rx_frame_end = 1'b1;
    endcase
    step();
    tx_done      = 1'b0;
    rx_start_bit = 1'b0;
    rx_frame_end = 1'b0;
  endtask

  task automatic wait_for(input string nm, input int which, input int lim, output int at);
    bit hit;
    hit = 1'b0;
    at  = -1;
    for (int i = 0; i < lim && !hit; i++) begin
      step();
      case (which)
        W_START: hit = tx_start;
        W_ACK:   hit = |ack;
        W_REP:   hit = |repeat_req;
        default: hit = fail;
      endcase
    end
    if (hit) at = cyc;
    else chk({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int t, td, cnt;

    // reset state
    repeat (3) step();
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    n_rst = 1'b1;
    step();

    // en low blocks grants
    req = 4'b0101;
    repeat (20) step();
    chk("en_off_busy", 32'(busy), 32'd0);

    // btc beats sr, no reply for btc, sr follows after the gap
    en = 1'b1;
    wait_for("t1_start", W_START, 10, t);
    chk("t1_sel", 32'(tx_sel), 32'd2);
    repeat (3) step();
    pulse(0);
    td = cyc;
    chk("t1_ack", 32'(ack), 32'b0100);
    req = 4'b0001;
    wait_for("t1_next", W_START, 40, t);
    chk("t1_sel2", 32'(tx_sel), 32'd0);
    chk("t1_gap", 32'(t - td), 32'd17);

    // sr gets no reply three times -> two repeats, then fail
    req = 4'd0;
    for (int a = 0; a < 3; a++) begin
      repeat (2) step();
      pulse(0);
      td = cyc;
      if (a < 2) begin
        wait_for("t3_rep", W_REP, 2100, t);
        chk("t3_rep_lat", 32'(t - td), 32'd2000);
        chk("t3_rep_val", 32'(repeat_req), 32'b0001);
        wait_for("t3_restart", W_START, 40, t);
        chk("t3_restart_sel", 32'(tx_sel), 32'd0);
      end else begin
        wait_for("t3_fail", W_FAIL, 2100, t);
        chk("t3_fail_lat", 32'(t - td), 32'd2000);
        chk("t3_switch", 32'(switch_com_src_req), 32'd1);
        chk("t3_fail_no_rep", 32'(repeat_req), 32'd0);
      end
    end
    cnt = 0;
    repeat (60) begin
      step();
      if (tx_start) cnt++;
    end
    chk("t3_no_4th", 32'(cnt), 32'd0);

    // ccw reply after 100 cycles, good frame
    req = 4'b1000;
    wait_for("t2_start", W_START, 10, t);
    chk("t2_sel", 32'(tx_sel), 32'd3);
    req = 4'd0;
    repeat (2) step();
    pulse(0);
    repeat (99) step();
    pulse(1);
    chk("t2_rx_busy", 32'(busy), 32'd1);
    repeat (5) step();
    pulse(2);
    chk("t2_ack", 32'(ack), 32'b1000);
    repeat (20) step();

    // tm reply with error, retry beats a new btc request
    req = 4'b0010;
    wait_for("t4_start", W_START, 10, t);
    chk("t4_sel", 32'(tx_sel), 32'd1);
    req = 4'd0;
    repeat (2) step();
    pulse(0);
    repeat (10) step();
    pulse(1);
    repeat (3) step();
    rx_err = 1'b1;
    pulse(2);
    rx_err = 1'b0;
    chk("t4_rep", 32'(repeat_req), 32'b0010);
    req = 4'b0100;
    wait_for("t4_retry", W_START, 40, t);
    chk("t4_retry_sel", 32'(tx_sel), 32'd1);
    repeat (2) step();
    pulse(0);
    repeat (5) step();
    pulse(1);
    step();
    pulse(2);
    chk("t4_ack", 32'(ack), 32'b0010);
    wait_for("t4_btc", W_START, 40, t);
    chk("t4_btc_sel", 32'(tx_sel), 32'd2);
    req = 4'd0;
    repeat (2) step();
    pulse(0);
    chk("t4_btc_ack", 32'(ack), 32'b0100);
    repeat (20) step();

    // start bit on the last cycle of the window wins over the timeout
    req = 4'b1000;
    wait_for("t5_start", W_START, 10, t);
    req = 4'd0;
    repeat (2) step();
    pulse(0);
    repeat (1999) step();
    pulse(1);
    chk("t5_no_rep", 32'(repeat_req), 32'd0);
    chk("t5_busy", 32'(busy), 32'd1);
    repeat (3) step();
    pulse(2);
    chk("t5_ack", 32'(ack), 32'b1000);
    repeat (20) step();

    // reset while waiting for tm's reply abandons it silently
    req = 4'b0010;
    wait_for("t6_start", W_START, 10, t);
    req = 4'd0;
    repeat (2) step();
    pulse(0);
    repeat (50) step();
    n_rst = 1'b0;
    step();
    chk("t6_tx_sel", 32'(tx_sel), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_outs", 32'({tx_start, ack, repeat_req, fail, switch_com_src_req}), 32'd0);
    n_rst = 1'b1;
    pulse(0);
    pulse(1);
    pulse(2);
    cnt = 0;
    repeat (2100) begin
      step();
      if (fail || switch_com_src_req || tx_start || (|repeat_req) || (|ack)) cnt++;
    end
    chk("t6_quiet", 32'(cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
